// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with head-to-tail packet locking.
// Grants and crossbar selects are combinational; only lock/owner/pointer state is registered.
module switch_allocator #(
  parameter int INPUT_NUM  = 2,
  parameter int OUTPUT_NUM = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [INPUT_NUM-1:0]                  req_valid_i,
  input  logic [INPUT_NUM*((OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1)-1:0] req_port_i,
  input  logic [INPUT_NUM-1:0]                  req_head_i,
  input  logic [INPUT_NUM-1:0]                  req_tail_i,
  input  logic [OUTPUT_NUM-1:0]                 out_ready_i,
  output logic [INPUT_NUM-1:0]                  grant_o,
  output logic [OUTPUT_NUM-1:0]                 out_valid_o,
  output logic [OUTPUT_NUM*((INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1)-1:0] sel_o
);
  localparam int SEL_SIZE = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
  localparam int DST_SIZE = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;

  // Handshake: a flit moves through the crossbar in exactly the cycle its input sees
  // grant_o high; grant implies req_valid_i and out_ready_i of the chosen output.
  logic [OUTPUT_NUM-1:0]                lock_q, lock_d;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  owner_q, owner_d;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  ptr_q, ptr_d;

  logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] req_m;
  logic [OUTPUT_NUM-1:0]                win_vld;
  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  win_idx;

  // Returns {found, index} of the first set candidate at or after ptr, wrapping.
  function automatic logic [SEL_SIZE:0] rr_pick(input logic [INPUT_NUM-1:0] cand,
                                                input logic [SEL_SIZE-1:0]  ptr);
    logic [SEL_SIZE:0]   res;
    logic [SEL_SIZE-1:0] sidx;
    int                  idx;
    res = '0;
    for (int k = INPUT_NUM - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= INPUT_NUM) idx = idx - INPUT_NUM;
      sidx = SEL_SIZE'(idx);
      if (cand[sidx]) res = {1'b1, sidx};
    end
    return res;
  endfunction

  function automatic logic [SEL_SIZE-1:0] ptr_after(input logic [SEL_SIZE-1:0] w);
    return (int'(w) == INPUT_NUM - 1) ? '0 : SEL_SIZE'(int'(w) + 1);
  endfunction

  always_comb begin
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        req_m[o][i] = req_valid_i[i] && (req_port_i[i*DST_SIZE +: DST_SIZE] == DST_SIZE'(o));
      end
    end
  end

  always_comb begin
    logic [SEL_SIZE:0] pick;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      win_vld[o] = 1'b0;
      win_idx[o] = '0;
      pick       = '0;
      if (rst_ni && out_ready_i[o]) begin
        if (lock_q[o]) begin
          win_vld[o] = req_m[o][owner_q[o]];
          win_idx[o] = owner_q[o];
        end else begin
          // Only head flits may open a new packet on an idle output.
          pick       = rr_pick(req_m[o] & req_head_i, ptr_q[o]);
          win_vld[o] = pick[SEL_SIZE];
          win_idx[o] = pick[SEL_SIZE-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_o     = '0;
    out_valid_o = '0;
    sel_o       = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      if (win_vld[o]) begin
        grant_o[win_idx[o]]             = 1'b1;
        out_valid_o[o]                  = 1'b1;
        sel_o[o*SEL_SIZE +: SEL_SIZE]   = win_idx[o];
      end
    end
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      if (win_vld[o]) begin
        if (lock_q[o]) begin
          if (req_tail_i[win_idx[o]]) lock_d[o] = 1'b0;
        end else begin
          ptr_d[o] = ptr_after(win_idx[o]);
          if (!req_tail_i[win_idx[o]]) begin
            lock_d[o]  = 1'b1;
            owner_d[o] = win_idx[o];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with 4 inputs and 4 outputs.
module tb_switch_allocator;
  localparam int IN_N  = 4;
  localparam int OUT_N = 4;

  logic             clk;
  logic             rst_n;
  logic [IN_N-1:0]  req_valid;
  logic [IN_N*2-1:0] req_port;
  logic [IN_N-1:0]  req_head;
  logic [IN_N-1:0]  req_tail;
  logic [OUT_N-1:0] out_ready;
  logic [IN_N-1:0]  grant;
  logic [OUT_N-1:0] out_valid;
  logic [OUT_N*2-1:0] sel;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  switch_allocator #(.INPUT_NUM(IN_N), .OUTPUT_NUM(OUT_N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_port_i(req_port),
    .req_head_i(req_head), .req_tail_i(req_tail),
    .out_ready_i(out_ready),
    .grant_o(grant), .out_valid_o(out_valid), .sel_o(sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] port,
                         input logic h, input logic t);
    req_valid[i]      = v;
    req_port[i*2 +: 2] = port;
    req_head[i]       = h;
    req_tail[i]       = t;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_port  = '0;
    req_head  = '0;
    req_tail  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    out_ready = '1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = '1;
    clear_req();
    #1;

    // 1: reset gating, then first grant
    for (int i = 0; i < IN_N; i++) set_req(i, 1'b1, 2'd0, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      tick();
    end
    rst_n = 1'b1;
    settle();
    check("post_rst_grant", 32'(grant), 32'b0001);
    check("post_rst_sel0", 32'(sel[1:0]), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'b0001);
    tick();

    // 2: round-robin on output 2
    do_reset();
    for (int i = 0; i < IN_N; i++) set_req(i, 1'b1, 2'd2, 1'b1, 1'b1);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      settle();
      check("rr_sel2", 32'(sel[5:4]), 32'(e));
      check("rr_grant", 32'(grant), 32'(4'b0001 << e));
      check("rr_valid", 32'(out_valid), 32'b0100);
      tick();
    end

    // 3: packet lock on output 3
    do_reset();
    set_req(1, 1'b1, 2'd3, 1'b1, 1'b0);
    set_req(2, 1'b1, 2'd3, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c == 1 || c == 2) set_req(1, 1'b1, 2'd3, 1'b0, 1'b0);
      if (c == 3)           set_req(1, 1'b1, 2'd3, 1'b0, 1'b1);
      settle();
      check("lock_grant", 32'(grant), 32'b0010);
      check("lock_sel3", 32'(sel[7:6]), 32'd1);
      tick();
    end
    set_req(1, 1'b0, 2'd0, 1'b0, 1'b0);
    settle();
    check("lock_next_grant", 32'(grant), 32'b0100);
    check("lock_next_sel3", 32'(sel[7:6]), 32'd2);
    tick();

    // 4: backpressure and bubble mid-packet
    do_reset();
    set_req(1, 1'b1, 2'd3, 1'b1, 1'b0);
    set_req(2, 1'b1, 2'd3, 1'b1, 1'b1);
    settle();
    check("bp_head", 32'(grant), 32'b0010);
    tick();
    set_req(1, 1'b1, 2'd3, 1'b0, 1'b0);
    out_ready[3] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("bp_stall_grant", 32'(grant), 32'h0);
      check("bp_stall_valid", 32'(out_valid), 32'h0);
      tick();
    end
    out_ready[3] = 1'b1;
    set_req(1, 1'b0, 2'd3, 1'b0, 1'b0);
    settle();
    check("bp_bubble_grant", 32'(grant), 32'h0);
    tick();
    set_req(1, 1'b1, 2'd3, 1'b0, 1'b0);
    settle();
    check("bp_body", 32'(grant), 32'b0010);
    tick();
    set_req(1, 1'b1, 2'd3, 1'b0, 1'b1);
    settle();
    check("bp_tail", 32'(grant), 32'b0010);
    tick();
    set_req(1, 1'b0, 2'd0, 1'b0, 1'b0);
    settle();
    check("bp_after", 32'(grant), 32'b0100);
    tick();

    // 5: independent outputs in parallel
    do_reset();
    set_req(0, 1'b1, 2'd1, 1'b1, 1'b1);
    set_req(3, 1'b1, 2'd0, 1'b1, 1'b1);
    settle();
    check("par_grant", 32'(grant), 32'b1001);
    check("par_valid", 32'(out_valid), 32'b0011);
    check("par_sel", 32'(sel), 32'h03);
    tick();

    // 6: reset in the middle of a packet
    do_reset();
    set_req(2, 1'b1, 2'd0, 1'b1, 1'b0);
    settle();
    check("mid_head", 32'(grant), 32'b0100);
    tick();
    set_req(2, 1'b1, 2'd0, 1'b0, 1'b0);
    settle();
    check("mid_body", 32'(grant), 32'b0100);
    tick();
    rst_n = 1'b0;
    set_req(2, 1'b1, 2'd0, 1'b0, 1'b1);
    settle();
    check("mid_rst_grant", 32'(grant), 32'h0);
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 2'd0, 1'b1, 1'b1);
    settle();
    check("mid_new_head", 32'(grant), 32'b0001);
    check("mid_new_sel0", 32'(sel[1:0]), 32'd0);
    tick();
    set_req(0, 1'b0, 2'd0, 1'b0, 1'b0);
    settle();
    check("mid_stale_tail", 32'(grant), 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Generates the per-output select vectors that drive the router crossbar, plus per-input grants back to the input buffers.
- Sits between the input-port buffers/route compute and the crossbar. It is the control end of the crossbar select interface.
- Performs round-robin arbitration per output port.
- Holds (locks) an output to one input from a head flit through its tail flit, so packets never interleave on a link.

Parameters:
- INPUT_NUM, 2, number of router input ports (requesters).
- OUTPUT_NUM, 2, number of router output ports.
- SEL_SIZE, max(1, clog2(INPUT_NUM)), localparam; width of one crossbar select.
- DST_SIZE, max(1, clog2(OUTPUT_NUM)), localparam; width of one destination-port field.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- req_valid_i  input  INPUT_NUM  bit i: input i holds a flit ready to forward.
- req_port_i  input  INPUT_NUM*DST_SIZE  slice i at [i*DST_SIZE +: DST_SIZE]: destination output of input i's flit.
- req_head_i  input  INPUT_NUM  bit i: input i's flit is a head flit.
- req_tail_i  input  INPUT_NUM  bit i: input i's flit is a tail flit. Single-flit packet = head and tail both set.
- out_ready_i  input  OUTPUT_NUM  bit o: output o (downstream credit) can accept a flit this cycle.
- grant_o  output  INPUT_NUM  bit i: input i's flit traverses the crossbar this cycle; the input pops it.
- out_valid_o  output  OUTPUT_NUM  bit o: output o carries a valid flit this cycle.
- sel_o  output  OUTPUT_NUM*SEL_SIZE  slice o: index of the input routed to output o; wired directly to the crossbar select inputs.

Behaviour:
- Grants are combinational from inputs and registered state: zero-cycle latency, with flit transfer in the same cycle as the grant. Only lock/owner/pointer state is sequential.
- Per-output state:
  - lock[o], reset 0.
  - owner[o] (SEL_SIZE bits), reset 0.
  - rr_ptr[o] (SEL_SIZE bits), reset 0.
- Input i requests output o when req_valid_i[i]=1 and req_port_i slice i == o. Requests with req_port >= OUTPUT_NUM are never granted.
- Output o, locked (lock[o]=1):
  - Grants owner[o] iff owner[o] requests o and out_ready_i[o]=1.
  - All other requesters of o are denied.
- Output o, unlocked:
  - Candidates are inputs requesting o with req_head_i=1. Non-head flits are denied (protocol error, no state change).
  - If out_ready_i[o]=1, the winner is the first candidate scanning from rr_ptr[o] upward, wrapping modulo INPUT_NUM.
- Grant outputs:
  - On a grant to input w for output o: out_valid_o[o]=1, sel_o[o]=w, grant_o[w]=1.
  - With no grant on output o: out_valid_o[o]=0, sel_o[o]=0.
  - Each input requests at most one output, so at most one grant_o bit per input is ever set.
- State update on a granted cycle (clock edge):
  - Head and not tail: lock[o]<=1, owner[o]<=w, rr_ptr[o]<=(w+1) mod INPUT_NUM.
  - Head and tail (single-flit packet): lock unchanged at 0, rr_ptr[o]<=(w+1) mod INPUT_NUM.
  - Body flit (locked): no change.
  - Tail flit (locked): lock[o]<=0. rr_ptr is unchanged, since it already advanced at the head.
- Stalls:
  - out_ready_i[o]=0 gives no grant on o, and lock/owner/rr_ptr of o hold.
  - A locked owner with req_valid low (bubble) gives no grant; the lock holds.
- Simultaneous tail grant and competing heads: the competing heads are denied in the tail cycle. They may win from the next cycle.
- Wrap-around: rr_ptr=INPUT_NUM-1 with winner INPUT_NUM-1 gives next pointer 0. For non-power-of-2 INPUT_NUM, the pointer never exceeds INPUT_NUM-1.
- Reset (rst_ni=0 at an edge, including mid-packet): clears all lock/owner/rr_ptr.
- While rst_ni=0: grant_o=0, out_valid_o=0, sel_o=0, regardless of requests.

Test Plan (INPUT_NUM=4, OUTPUT_NUM=4 unless noted):
1. Reset: hold rst_ni=0 two cycles with all inputs requesting output 0, head=1 -> grant_o=0000, out_valid_o=0000, sel_o=0. First cycle after release -> grant_o=0001, sel_o[0]=0.
2. Round-robin fairness: inputs 0,1,2,3 send continuous single-flit packets (head=tail=1) to output 2, out_ready=1 -> sel_o[2] sequence 0,1,2,3,0; one grant per cycle.
3. Packet lock: input 1 sends a 4-flit packet (H,B,B,T) to output 3 while input 2 offers a head to output 3 -> input 1 granted 4 consecutive cycles; input 2 granted in cycle 5; sel_o[3]=1,1,1,1,2.
4. Backpressure/bubble mid-packet: out_ready_i[3]=0 for 2 cycles after the head, then the owner drops req_valid for 1 cycle -> no grants on output 3 in those 3 cycles; input 2's head still denied; the packet completes afterwards.
5. Parallel outputs: input 0 to output 1 and input 3 to output 0, same cycle -> grant_o=1001, sel_o[1]=0, sel_o[0]=3, out_valid_o=0011.
6. Reset mid-packet: assert rst_ni=0 after the head+body of a 3-flit packet from input 2 to output 0 -> lock cleared. After release, a head from input 0 is granted immediately and input 2's stale tail is denied.
